// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package hazard_pkg;

    // Tag address fields are stored at a fixed width so one struct fits
    // every REG_ADDR_W up to 8. Narrower addresses are zero-extended.
    localparam int TAG_ADDR_W = 8;

    // R15 is the PC. It is never a hazard or forwarding target.
    localparam logic [TAG_ADDR_W-1:0] PC_REG = TAG_ADDR_W'(15);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_ADDR_W-1:0] dst;
        logic                  reg_write;
        logic                  is_load;
        logic [TAG_ADDR_W-1:0] src1;
        logic                  src1_used;
        logic [TAG_ADDR_W-1:0] src2;
        logic                  src2_used;
    } stage_tag_t;

    // Producer stage s writes the register that a consumer reads through 'addr'.
    function automatic logic tag_match(stage_tag_t s, logic [TAG_ADDR_W-1:0] addr, logic used);
        return s.valid && s.reg_write && used && (s.dst == addr) && (addr != PC_REG);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: ID-stage tags and pipeline status in; stall, flush, freeze and forwarding selects out.
// Latency: n/a (signal bundle only).
// Backpressure: n/a. The pipeline side is master; the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1_addr;
    logic [REG_ADDR_W-1:0] id_src2_addr;
    logic                  id_src1_used;
    logic                  id_src2_used;
    logic [REG_ADDR_W-1:0] id_dst_addr;
    logic                  id_reg_write;
    logic                  id_mem_to_reg;
    logic                  ex_branch_taken;
    logic                  mem_busy;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pipe_freeze;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;

    modport master (
        output id_valid, id_src1_addr, id_src2_addr, id_src1_used, id_src2_used,
               id_dst_addr, id_reg_write, id_mem_to_reg, ex_branch_taken, mem_busy,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze,
               fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_valid, id_src1_addr, id_src2_addr, id_src1_used, id_src2_used,
               id_dst_addr, id_reg_write, id_mem_to_reg, ex_branch_taken, mem_busy,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze,
               fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/hazard_stage_tag.sv
// Purpose: one shadow pipeline stage of register tags. Ports: clk, reset (async active-low), hold, bubble, load, d, q.
// Latency: 1 cycle from d to q.
// Backpressure: hold keeps q and has priority; otherwise bubble clears q, or load captures d.
module hazard_stage_tag
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       bubble,
    input  logic       load,
    input  stage_tag_t d,
    output stage_tag_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                q <= '0;
            end else if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: load-use stall, branch flush, memory freeze and EX forwarding selects for the 5-stage pipe.
//          Ports: clk, reset (async active-low), hz (slave modport of pipeline_hazard_ctrl_if).
// Latency: stall/flush/freeze are combinational in the same cycle; forwarding selects come from registered shadows.
// Backpressure: mem_busy freezes the shadows and the FSM, and overrides every flush.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = 4,  // at most TAG_ADDR_W
    parameter int LOAD_USE_STALLS = 1   // 1..7
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [2:0] CNT_LOAD = 3'(LOAD_USE_STALLS - 1);

    stage_tag_t id_tag;
    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;
    hz_state_t  state;
    logic [2:0] cnt;
    logic       load_use;
    logic       stall_req;
    logic       id_accept;

    always_comb begin
        id_tag           = '0;
        id_tag.valid     = hz.id_valid;
        id_tag.dst       = TAG_ADDR_W'(hz.id_dst_addr);
        id_tag.reg_write = hz.id_reg_write;
        id_tag.is_load   = hz.id_mem_to_reg;
        id_tag.src1      = TAG_ADDR_W'(hz.id_src1_addr);
        id_tag.src1_used = hz.id_src1_used;
        id_tag.src2      = TAG_ADDR_W'(hz.id_src2_addr);
        id_tag.src2_used = hz.id_src2_used;
    end

    assign load_use  = hz.id_valid && ex_q.is_load &&
                       (tag_match(ex_q, id_tag.src1, id_tag.src1_used) ||
                        tag_match(ex_q, id_tag.src2, id_tag.src2_used));
    assign stall_req = (state == LU_STALL) || load_use;

    // Priority: memory wait, then branch, then load-use stall.
    always_comb begin
        hz.pc_stall    = 1'b0;
        hz.if_id_stall = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.pipe_freeze = 1'b0;
        if (hz.mem_busy) begin
            hz.pipe_freeze = 1'b1;
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (stall_req) begin
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            hz.id_ex_flush = 1'b1;
        end
    end

    // ID enters EX only when nothing stalls or flushes it; otherwise EX takes a bubble.
    assign id_accept = hz.id_valid && !hz.mem_busy && !hz.ex_branch_taken && !stall_req;

    hazard_stage_tag u_ex (
        .clk(clk), .reset(reset), .hold(hz.mem_busy), .bubble(!id_accept),
        .load(id_accept), .d(id_tag), .q(ex_q)
    );
    hazard_stage_tag u_mem (
        .clk(clk), .reset(reset), .hold(hz.mem_busy), .bubble(1'b0),
        .load(1'b1), .d(ex_q), .q(mem_q)
    );
    // WB drains while frozen, because MEM/WB takes a bubble.
    hazard_stage_tag u_wb (
        .clk(clk), .reset(reset), .hold(1'b0), .bubble(hz.mem_busy),
        .load(1'b1), .d(mem_q), .q(wb_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (!hz.mem_busy) begin
            if (hz.ex_branch_taken) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (load_use && (LOAD_USE_STALLS > 1)) begin
                            state <= LU_STALL;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    LU_STALL: begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    // The newest producer wins. A load sitting in MEM has no value yet, so it is skipped.
    function automatic logic [1:0] fwd_pick(logic [TAG_ADDR_W-1:0] src, logic used);
        if (tag_match(mem_q, src, used) && !mem_q.is_load) begin
            return FWD_MEM;
        end else if (tag_match(wb_q, src, used)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign hz.fwd_a_sel = fwd_pick(ex_q.src1, ex_q.src1_used);
    assign hz.fwd_b_sel = fwd_pick(ex_q.src2, ex_q.src2_used);

    // Source tags of the later stages are carried only to keep every stage identical.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{mem_q.src1, mem_q.src1_used, mem_q.src2, mem_q.src2_used,
                               wb_q.src1, wb_q.src1_used, wb_q.src2, wb_q.src2_used,
                               wb_q.is_load, ex_q.valid};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // ctl order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze}
    localparam logic [4:0] C_IDLE   = 5'b00000;
    localparam logic [4:0] C_STALL  = 5'b11010;
    localparam logic [4:0] C_FLUSH  = 5'b00110;
    localparam logic [4:0] C_FREEZE = 5'b11001;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4)) bus ();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4)) bus3 ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_USE_STALLS(1)) dut (
        .clk(clk), .reset(rst_n), .hz(bus)
    );
    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_USE_STALLS(3)) dut3 (
        .clk(clk), .reset(rst_n), .hz(bus3)
    );

    task automatic set_id(input bit sel3, input bit vld, input int dst, input bit rw, input bit ld,
                          input int s1, input bit u1, input int s2, input bit u2);
        if (sel3) begin
            bus3.id_valid = vld; bus3.id_dst_addr = 4'(dst); bus3.id_reg_write = rw;
            bus3.id_mem_to_reg = ld; bus3.id_src1_addr = 4'(s1); bus3.id_src1_used = u1;
            bus3.id_src2_addr = 4'(s2); bus3.id_src2_used = u2;
        end else begin
            bus.id_valid = vld; bus.id_dst_addr = 4'(dst); bus.id_reg_write = rw;
            bus.id_mem_to_reg = ld; bus.id_src1_addr = 4'(s1); bus.id_src1_used = u1;
            bus.id_src2_addr = 4'(s2); bus.id_src2_used = u2;
        end
    endtask

    task automatic idle(input bit sel3);
        set_id(sel3, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic chk_ctl(input string tag, input bit sel3, input logic [4:0] exp);
        logic [4:0] obs;
        obs = sel3 ? {bus3.pc_stall, bus3.if_id_stall, bus3.if_id_flush, bus3.id_ex_flush, bus3.pipe_freeze}
                   : {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_flush, bus.pipe_freeze};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_fwd(input string tag, input bit sel3, input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] obs;
        obs = sel3 ? {bus3.fwd_a_sel, bus3.fwd_b_sel} : {bus.fwd_a_sel, bus.fwd_b_sel};
        vectors++;
        assert (obs === {ea, eb}) else begin
            miscompares++;
            $error("FAIL %s: fwd a/b observed %b expected %b", tag, obs, {ea, eb});
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle(1'b0); idle(1'b1);
        bus.ex_branch_taken = 1'b0;  bus.mem_busy = 1'b0;
        bus3.ex_branch_taken = 1'b0; bus3.mem_busy = 1'b0;
        #2;
        chk_ctl("reset_ctl", 1'b0, C_IDLE);
        chk_fwd("reset_fwd", 1'b0, 2'b00, 2'b00);
        chk_ctl("reset_ctl3", 1'b1, C_IDLE);
        rst_n = 1'b1;

        // Load-use, one bubble: LDR R1 then ADD R2,R1,R3
        set_id(0, 1, 1, 1, 1, 0, 1, 0, 0); #1; chk_ctl("ldr_issue", 0, C_IDLE); next_cyc();
        set_id(0, 1, 2, 1, 0, 1, 1, 3, 1); #1; chk_ctl("lu_stall", 0, C_STALL); next_cyc();
        #1; chk_ctl("lu_release", 0, C_IDLE); next_cyc();
        idle(0); #1; chk_fwd("lu_fwd_wb", 0, 2'b10, 2'b00); next_cyc();

        // ALU chain: ADD R4 ; SUB R5,R4,R4 ; ORR R8,R4,R9
        set_id(0, 1, 4, 1, 0, 6, 1, 7, 1); next_cyc();
        set_id(0, 1, 5, 1, 0, 4, 1, 4, 1); #1; chk_ctl("alu_nostall", 0, C_IDLE); next_cyc();
        set_id(0, 1, 8, 1, 0, 4, 1, 9, 1); #1; chk_fwd("alu_fwd_mem", 0, 2'b01, 2'b01); next_cyc();
        // ADD R10 twice, then AND R11,R10,R10: MEM copy beats WB copy
        set_id(0, 1, 10, 1, 0, 6, 1, 7, 1); #1; chk_fwd("alu_fwd_wb", 0, 2'b10, 2'b00); next_cyc();
        set_id(0, 1, 10, 1, 0, 6, 1, 7, 1); next_cyc();
        set_id(0, 1, 11, 1, 0, 10, 1, 10, 1); next_cyc();
        idle(0); #1; chk_fwd("fwd_newest", 0, 2'b01, 2'b01); next_cyc();

        // Branch together with load-use: branch wins
        set_id(0, 1, 1, 1, 1, 0, 1, 0, 0); next_cyc();
        set_id(0, 1, 2, 1, 0, 1, 1, 3, 1); bus.ex_branch_taken = 1'b1;
        #1; chk_ctl("br_over_lu", 0, C_FLUSH); next_cyc();
        bus.ex_branch_taken = 1'b0; idle(0); #1; chk_ctl("br_after", 0, C_IDLE); next_cyc();

        // mem_busy masks a taken branch
        bus.mem_busy = 1'b1; bus.ex_branch_taken = 1'b1;
        #1; chk_ctl("busy_ignores_br", 0, C_FREEZE); next_cyc();
        bus.mem_busy = 1'b0; bus.ex_branch_taken = 1'b0;

        // R15: LDR R15 then ADD R3,R15,R15 (no stall); MOV R15 then ADD R3,R15,R15 (no forward)
        set_id(0, 1, 15, 1, 1, 0, 1, 0, 0); next_cyc();
        set_id(0, 1, 3, 1, 0, 15, 1, 15, 1); #1; chk_ctl("r15_no_stall", 0, C_IDLE); next_cyc();
        set_id(0, 1, 15, 1, 0, 6, 1, 0, 0); next_cyc();
        set_id(0, 1, 3, 1, 0, 15, 1, 15, 1); next_cyc();
        idle(0); #1; chk_fwd("r15_no_fwd", 0, 2'b00, 2'b00); next_cyc();

        // Three bubbles with a 2-cycle memory wait in the middle
        set_id(1, 1, 1, 1, 1, 0, 1, 0, 0); next_cyc();
        set_id(1, 1, 2, 1, 0, 1, 1, 3, 1); #1; chk_ctl("lu3_b1", 1, C_STALL); next_cyc();
        bus3.mem_busy = 1'b1; #1; chk_ctl("lu3_frz1", 1, C_FREEZE); next_cyc();
        #1; chk_ctl("lu3_frz2", 1, C_FREEZE); next_cyc();
        bus3.mem_busy = 1'b0; #1; chk_ctl("lu3_b2", 1, C_STALL); next_cyc();
        #1; chk_ctl("lu3_b3", 1, C_STALL); next_cyc();
        #1; chk_ctl("lu3_done", 1, C_IDLE); next_cyc();
        idle(1); #1; chk_fwd("lu3_fwd", 1, 2'b00, 2'b00); next_cyc();

        // Branch during LU_STALL returns to RUN
        set_id(1, 1, 1, 1, 1, 0, 1, 0, 0); next_cyc();
        set_id(1, 1, 2, 1, 0, 1, 1, 3, 1); #1; chk_ctl("lu3_enter", 1, C_STALL); next_cyc();
        bus3.ex_branch_taken = 1'b1; #1; chk_ctl("br_in_lustall", 1, C_FLUSH); next_cyc();
        bus3.ex_branch_taken = 1'b0; idle(1); #1; chk_ctl("br_exit_run", 1, C_IDLE); next_cyc();

        // Branch together with load-use in RUN: no LU_STALL entry
        set_id(1, 1, 1, 1, 1, 0, 1, 0, 0); next_cyc();
        set_id(1, 1, 2, 1, 0, 1, 1, 3, 1); bus3.ex_branch_taken = 1'b1;
        #1; chk_ctl("br_lu_run3", 1, C_FLUSH); next_cyc();
        bus3.ex_branch_taken = 1'b0; idle(1); #1; chk_ctl("br_lu_stay_run", 1, C_IDLE); next_cyc();

        // Reset in the middle of LU_STALL
        set_id(1, 1, 1, 1, 1, 0, 1, 0, 0); next_cyc();
        set_id(1, 1, 2, 1, 0, 1, 1, 3, 1); #1; chk_ctl("rst_pre_stall", 1, C_STALL); next_cyc();
        idle(1); rst_n = 1'b0; #1;
        chk_ctl("rst_ctl_mid", 1, C_IDLE);
        chk_fwd("rst_fwd_mid", 1, 2'b00, 2'b00);
        rst_n = 1'b1;
        next_cyc();
        set_id(1, 1, 2, 1, 0, 1, 1, 3, 1); #1; chk_ctl("rst_no_stall", 1, C_IDLE); next_cyc();
        idle(1); #1; chk_fwd("rst_first_fwd", 1, 2'b00, 2'b00); next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
